stage4_accumulator: RTL

//  Downstream neighbour of the SD4 MAC adder-tree stage (Stage3). Consumes the registered
//  20-bit signed partial-product sum, accumulates acc_len consecutive sums into a wide

---
 rtl/stage4_accumulator_pkg.sv | 23 ++
 rtl/stage4_accumulator_sat_clamp.sv | 28 ++
 rtl/stage4_accumulator.sv | 114 +++++++++++
 3 files changed

// File: rtl/stage4_accumulator_pkg.sv
// Shared types and output-range helpers for the Stage4 accumulator.
package stage4_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ACC  = 2'd1,
    WAIT = 2'd2
  } state_e;

  localparam int OUT_W_DEF = 24;

  function automatic longint out_max(input int w);
    return (longint'(1) <<< (w - 1)) - 1;
  endfunction

  function automatic longint out_min(input int w);
    return -(longint'(1) <<< (w - 1));
  endfunction

  localparam longint OUT_MAX = out_max(OUT_W_DEF);
  localparam longint OUT_MIN = out_min(OUT_W_DEF);

endpackage

// File: rtl/stage4_accumulator_sat_clamp.sv
// Clamps a wide signed accumulator to the signed OUT_W output range.
module sat_clamp
  import stage4_pkg::*;
#(
  parameter int ACC_W = 32,
  parameter int OUT_W = OUT_W_DEF
) (
  input  logic signed [ACC_W-1:0] acc_i,
  output logic        [OUT_W-1:0] data_o,
  output logic                    sat_o
);

  localparam logic signed [ACC_W-1:0] MAX_V = ACC_W'(out_max(OUT_W));
  localparam logic signed [ACC_W-1:0] MIN_V = ACC_W'(out_min(OUT_W));

  always_comb begin
    sat_o  = 1'b0;
    data_o = acc_i[OUT_W-1:0];
    if (acc_i > MAX_V) begin
      sat_o  = 1'b1;
      data_o = MAX_V[OUT_W-1:0];
    end else if (acc_i < MIN_V) begin
      sat_o  = 1'b1;
      data_o = MIN_V[OUT_W-1:0];
    end
  end

endmodule

// File: rtl/stage4_accumulator.sv
// Accumulates acc_len Stage3 sums, saturates, and holds one result behind a valid/ready port.
module stage4_accumulator
  import stage4_pkg::*;
#(
  parameter int IN_W  = 20,
  parameter int ACC_W = 32,
  parameter int OUT_W = OUT_W_DEF,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [IN_W-1:0]  in_sum,
  input  logic [CNT_W-1:0] acc_len,
  input  logic             in_clear,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [OUT_W-1:0] out_data,
  output logic             out_sat,
  output logic             busy
);

  state_e                  state_q, state_d;
  logic signed [ACC_W-1:0] acc_q, acc_d;
  logic        [CNT_W-1:0] cnt_q, len_q;
  logic                    out_valid_q, out_sat_q;
  logic        [OUT_W-1:0] out_data_q;

  logic signed [ACC_W-1:0] sum_ext, clamp_in;
  logic        [CNT_W-1:0] len_eff;
  logic                    beat, last_beat, slot_free, load;
  logic        [OUT_W-1:0] clamp_data;
  logic                    clamp_sat;

  assign sum_ext   = {{(ACC_W-IN_W){in_sum[IN_W-1]}}, in_sum};
  assign len_eff   = (acc_len == '0) ? CNT_W'(1) : acc_len;
  assign beat      = in_valid & in_ready;
  assign acc_d     = (state_q == IDLE) ? sum_ext : acc_q + sum_ext;
  assign last_beat = beat & ((state_q == IDLE) ? (len_eff == CNT_W'(1))
                                               : (cnt_q == len_q - CNT_W'(1)));
  assign slot_free = ~out_valid_q | out_ready;

  // In WAIT the held (unclamped) total lives in acc_q; otherwise clamp the value being finished.
  assign clamp_in = (state_q == WAIT) ? acc_q : acc_d;
  assign load     = (last_beat & slot_free) | ((state_q == WAIT) & out_ready);

  sat_clamp #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_sat (
    .acc_i  (clamp_in),
    .data_o (clamp_data),
    .sat_o  (clamp_sat)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE, ACC: begin
        if (in_clear)       state_d = IDLE;
        else if (last_beat) state_d = slot_free ? IDLE : WAIT;
        else if (beat)      state_d = ACC;
      end
      WAIT:    if (out_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready = (state_q != WAIT) & ~in_clear;
    busy     = (state_q != IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      acc_q <= '0;
      cnt_q <= '0;
      len_q <= '0;
    end else if (state_q != WAIT && in_clear) begin
      acc_q <= '0;
      cnt_q <= '0;
    end else if (beat) begin
      acc_q <= acc_d;
      if (state_q == IDLE) begin
        cnt_q <= CNT_W'(1);
        len_q <= len_eff;
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_sat_q   <= 1'b0;
    end else if (load) begin
      out_valid_q <= 1'b1;
      out_data_q  <= clamp_data;
      out_sat_q   <= clamp_sat;
    end else if (out_ready) begin
      out_valid_q <= 1'b0;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_sat   = out_sat_q;

endmodule
